// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the load path: word width, load funct3
// encodings, load error codes and small decode helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } load_err_e;

  // True for the five load encodings the core supports.
  function automatic logic funct3_legal(input logic [2:0] f);
    case (f)
      LB, LH, LW, LBU, LHU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    case (f)
      LH, LHU: return a[0];
      LW:      return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Byte/half/word selection from an aligned read word, with sign or zero
// extension according to the load type.
module load_extract
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select from the byte offset within the word.
  always_comb begin
    w_byte = '0;
    case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = '0;
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension by load type.
  always_comb begin
    o_data = '0;
    case (i_funct3)
      LB:      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LBU:     o_data = {{(XLEN-8){1'b0}}, w_byte};
      LH:      o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LHU:     o_data = {{(XLEN-16){1'b0}}, w_half};
      LW:      o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multicycle data-memory load sequencer: one aligned read over a
// req/gnt/rvalid port, extraction/extension of the result, and error
// reporting for bad funct3, misalignment and an unresponsive memory.
module load_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [2:0]      funct3_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] data_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_off;
  logic [2:0]      r_funct3;
  logic            r_done;
  logic            r_err;
  load_err_e       r_err_code;
  logic [XLEN-1:0] r_data;
  logic            r_req;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] w_ext;
  logic            w_expired;

  load_extract u_extract (
    .i_rdata  (mem_rdata_i),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  // The counter runs across REQ and WAIT without clearing, so a late grant
  // can leave it at or past the limit on entry to WAIT; compare with >=.
  assign w_expired = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

  // Load sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_off      <= '0;
      r_funct3   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_data     <= '0;
      r_req      <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start_i) begin
            if (!funct3_legal(funct3_i)) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= ERR_FUNCT3;
              r_data     <= '0;
            end else if (misaligned(funct3_i, addr_i[1:0])) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= ERR_MISALIGN;
              r_data     <= '0;
            end else begin
              r_state    <= S_REQ;
              r_off      <= addr_i[1:0];
              r_funct3   <= funct3_i;
              r_mem_addr <= {addr_i[XLEN-1:2], 2'b00};
              r_cnt      <= '0;
              r_req      <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_gnt_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end else if (w_expired) begin
            r_state    <= S_DONE;
            r_req      <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_data     <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_rvalid_i) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_data     <= w_ext;
          end else if (w_expired) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_data     <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;
  assign data_o     = r_data;
  assign mem_req_o  = r_req;
  assign mem_addr_o = r_mem_addr;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a scoreboard: expected completions are
// queued by the stimulus and checked by a monitor on every done_o pulse.
module tb_load_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        busy_o, done_o, err_o, mem_req_o;
  logic [31:0] data_o, mem_addr_o;
  logic [1:0]  err_code_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];

  load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .addr_i       (addr_i),
    .funct3_i     (funct3_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .data_o       (data_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rstn_i && done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", data_o, e.data);
        chk("sb_err", 32'(err_o), 32'(e.err));
        chk("sb_code", 32'(err_code_o), 32'(e.code));
      end
    end
  end

  // Successful load: gnt after gnt_wait idle REQ cycles, rvalid in the
  // first WAIT cycle. With spurious set, start and rvalid are also driven
  // during the idle REQ cycles and must have no effect.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input int gnt_wait, input bit spurious);
    exp_q.push_back('{data: exp_data, err: 1'b0, code: 2'b00});
    start_i  = 1'b1;
    addr_i   = addr;
    funct3_i = f3;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      if (spurious) begin
        start_i      = 1'b1;
        addr_i       = 32'h300;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
      end
      chk("req_held", 32'(mem_req_o), 32'd1);
      chk("req_addr_stable", mem_addr_o, {addr[31:2], 2'b00});
      tick();
    end
    start_i      = 1'b0;
    mem_rvalid_i = 1'b0;
    chk("req_on", 32'(mem_req_o), 32'd1);
    chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("req_off_wait", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
    chk("done_latency", 32'(done_o), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
  endtask

  // Error detected in IDLE: done the next cycle and no request at all.
  task automatic run_err(input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] code);
    exp_q.push_back('{data: 32'h0, err: 1'b1, code: code});
    start_i  = 1'b1;
    addr_i   = addr;
    funct3_i = f3;
    tick();
    start_i = 1'b0;
    chk("err_done_latency", 32'(done_o), 32'd1);
    chk("err_no_req", 32'(mem_req_o), 32'd0);
    tick();
    chk("err_no_req2", 32'(mem_req_o), 32'd0);
    chk("err_idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    run_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0);
    run_load(3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80, 0, 1'b0);
    run_load(3'b100, 32'h103, 32'h80123456, 32'h00000080, 0, 1'b0);
    run_load(3'b101, 32'h102, 32'h80123456, 32'h00008012, 0, 1'b0);
    run_load(3'b001, 32'h100, 32'h80123456, 32'h00003456, 0, 1'b0);
    run_load(3'b001, 32'h102, 32'h80123456, 32'hFFFF8012, 0, 1'b0);
    run_load(3'b000, 32'h101, 32'h80123456, 32'h00000034, 1, 1'b0);

    run_err(3'b001, 32'h101, 2'b01);
    run_err(3'b010, 32'h102, 2'b01);
    run_err(3'b011, 32'h101, 2'b10);
    run_err(3'b110, 32'h100, 2'b10);

    // Timeout: gnt in the first REQ cycle, rvalid never; four REQ+WAIT cycles.
    exp_q.push_back('{data: 32'h0, err: 1'b1, code: 2'b11});
    start_i  = 1'b1;
    addr_i   = 32'h140;
    funct3_i = 3'b010;
    tick();
    start_i   = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    tick();
    tick();
    chk("to_not_yet", 32'(done_o), 32'd0);
    chk("to_busy", 32'(busy_o), 32'd1);
    tick();
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_req_dropped", 32'(mem_req_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h11111111;
    tick();
    chk("late_rv_busy", 32'(busy_o), 32'd0);
    chk("late_rv_done", 32'(done_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b0;
    chk("late_rv_data", data_o, 32'd0);

    // Late grant on the last allowed REQ cycle wins over the timeout; a
    // second start and a stray rvalid during REQ are ignored.
    run_load(3'b010, 32'h200, 32'h12345678, 32'h12345678, 3, 1'b1);
    tick();
    tick();
    chk("no_second_load", 32'(busy_o), 32'd0);

    // Reset during WAIT clears everything immediately.
    start_i  = 1'b1;
    addr_i   = 32'h180;
    funct3_i = 3'b010;
    tick();
    start_i   = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_data", data_o, 32'd0);
    chk("arst_addr", mem_addr_o, 32'd0);
    chk("arst_req", 32'(mem_req_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();
    run_load(3'b010, 32'h1C0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1'b0);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side counterpart to the datapath's write-enabled state registers.
- Sequences a single data-memory load for the multicycle core:
  - issues a word-aligned request over a req/gnt/rvalid interface;
  - waits for the response;
  - extracts and sign/zero-extends the byte, half or word.
- Returns the result with a one-cycle done pulse. Illegal funct3, misaligned addresses and a non-responding memory are reported as errors.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the load aborts with a timeout error (≥2).

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  begin load; sampled only in IDLE
- addr_i  in  XLEN  byte address; sampled with start_i
- funct3_i  in  3  load type, from riscv_pkg: LB=000, LH=001, LW=010, LBU=100, LHU=101
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- data_o  out  XLEN  extended load result; held until the next done_o
- err_o  out  1  valid with done_o; error occurred
- err_code_o  out  2  valid with done_o: 00 none, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_req_o  out  1  memory read request
- mem_addr_o  out  XLEN  {addr[XLEN-1:2], 2'b00}
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  read word

Behaviour:
- Reset (async, rstn_i low):
  - state → IDLE;
  - all outputs 0, including data_o, err_code_o and mem_addr_o;
  - timeout counter → 0.
  - A reset mid-load abandons the transaction. No memory handshake is completed.
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered or decoded from state/registers; no combinational input-to-output paths.
- IDLE:
  - start_i=1 with illegal funct3 → DONE with err_code 10.
  - Else, misaligned access (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) → DONE with err_code 01.
  - In both error cases no memory request is made. Illegal funct3 has priority over misaligned.
  - Otherwise latch addr[1:0], funct3 and mem_addr_o, clear the counter, and go to REQ.
- REQ:
  - mem_req_o=1, held stable until mem_gnt_i.
  - mem_gnt_i=1 → WAIT, with mem_req_o deasserted the next cycle.
  - mem_rvalid_i in REQ is ignored.
- WAIT:
  - mem_rvalid_i=1 → register the extracted data into data_o, err_code 00, go to DONE.
- Timeout:
  - The counter increments every cycle in REQ and WAIT.
  - If the counter reaches TIMEOUT_CYCLES-1 and no gnt (REQ) or rvalid (WAIT) arrives that cycle → DONE with err_code 11, mem_req_o dropped.
  - If the completion event and the timeout occur in the same cycle, the completion event wins.
- DONE:
  - done_o=1 and err_o=(err_code!=00) for exactly one cycle, then → IDLE.
  - On error, data_o=0.
- start_i outside IDLE is ignored; no queuing.
- A late rvalid arriving in IDLE or DONE (e.g. after a timeout) is ignored.
- Latency:
  - Success with gnt in the first REQ cycle and rvalid in the first WAIT cycle: done_o 3 cycles after the start_i edge.
  - Error detected in IDLE: done_o 1 cycle after start_i.
- Extraction, with off=addr[1:0]:
  - byte = rdata[8*off +: 8];
  - half = rdata[16*off[1] +: 16];
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.

Decomposition:
- riscv_pkg:
  - XLEN;
  - load_funct3_e enum (LB, LH, LW, LBU, LHU);
  - load_err_e enum (ERR_NONE, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT).
- FSM state typedef stays local to the module.
- One combinational sub-module, load_extract (rdata, off, funct3 → extended XLEN result). It is also reusable for the test model.

Test Plan:
- LW at addr 0x100, gnt same cycle as req, rvalid next cycle with rdata 0xDEADBEEF → mem_addr_o=0x100; data_o=0xDEADBEEF, err_o=0; done_o 3 cycles after start.
- LB at addr 0x103, rdata 0x80123456 → data_o=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012. LH at 0x100 → 0x00003456.
- LH at addr 0x101 → no mem_req_o ever; done_o next cycle, err_code 01, data_o=0. funct3=011 with addr 0x101 → err_code 10.
- TIMEOUT_CYCLES=4, gnt given, rvalid never → done_o with err_code 11 after 4 REQ+WAIT cycles. A later rvalid is ignored, busy_o=0.
- gnt delayed 3 cycles, with start_i pulsed again mid-load and a spurious rvalid in REQ → mem_req_o stays high and stable; the single load completes correctly; the second start is ignored.
- rstn_i asserted during WAIT → all outputs 0 immediately. After release, a fresh LW completes normally.
